// File: rtl/data_memory_p.sv
// Single-port data RAM for the CORG datapath with per-byte write enables and self-clear after reset.
// Latency: 1 cycle for read (read_data/read_valid registered) and write; clear takes DEPTH cycles.
// Backpressure: none; requests are ignored until ready, after which one request per cycle is accepted.
// Optional byte parity is enabled by defining DATA_MEMORY_P_PARITY_EN.
module data_memory_p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                write_enable,
    input  logic                read_enable,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    output logic                ready,
    output logic                par_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]  read_data_q, read_data_d;
    logic               read_valid_q, read_valid_d;
    logic               ready_q, ready_d;

    // Storage array; never reset asynchronously, cleared word by word instead.
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               in_range;
    logic               rd_fire;
    logic               wr_fire;
    logic               clr_fire;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  old_word;
    logic [DATA_W-1:0]  merged_word;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]  mem_wdata;

`ifdef DATA_MEMORY_P_PARITY_EN
    // One even-parity bit per stored byte.
    logic [NB-1:0]      par_mem [DEPTH];
    logic [NB-1:0]      old_par;
    logic [NB-1:0]      merged_par;
    logic [NB-1:0]      calc_par;
    logic [NB-1:0]      mem_wpar;
    logic               par_mismatch;
    logic               par_err_q, par_err_d;
`endif

    // Request decode and the write-first merge of the addressed word.
    always_comb begin
        idx      = address[IDX_W-1:0];
        in_range = ({1'b0, address} < DEPTH_C);
        clr_fire = (state_q == ST_CLEAR);
        rd_fire  = (state_q == ST_IDLE) && read_enable;
        wr_fire  = (state_q == ST_IDLE) && write_enable && in_range;

        old_word    = in_range ? mem[idx] : '0;
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (write_enable && byte_en[i]) begin
                merged_word[8*i +: 8] = write_data[8*i +: 8];
            end
        end

        // The clear sequence owns the port while it runs.
        mem_we    = clr_fire || wr_fire;
        mem_idx   = clr_fire ? clr_cnt_q : idx;
        mem_wdata = clr_fire ? '0 : merged_word;
    end

`ifdef DATA_MEMORY_P_PARITY_EN
    // Parity of the merged word: fresh parity for written bytes, stored parity elsewhere.
    always_comb begin
        old_par    = in_range ? par_mem[idx] : '0;
        merged_par = old_par;
        calc_par   = '0;
        for (int i = 0; i < NB; i++) begin
            calc_par[i] = ^merged_word[8*i +: 8];
            if (write_enable && byte_en[i]) begin
                merged_par[i] = ^write_data[8*i +: 8];
            end
        end
        par_mismatch = |(calc_par ^ merged_par);
        mem_wpar     = clr_fire ? '0 : merged_par;
    end
`endif

    // Next-state logic for the clear/idle sequencer and the registered read port.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        ready_d      = ready_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_C) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                    ready_d   = 1'b1;
                end
            end
            ST_IDLE: begin
                ready_d = 1'b1;
                if (rd_fire) begin
                    // Out-of-range reads still complete, returning zero.
                    read_data_d  = in_range ? merged_word : '0;
                    read_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

`ifdef DATA_MEMORY_P_PARITY_EN
    // Parity error only reported alongside an in-range read.
    always_comb begin
        par_err_d = rd_fire && in_range && par_mismatch;
    end
`endif

    // Control and output registers; reset restarts the clear and drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            ready_q      <= 1'b0;
`ifdef DATA_MEMORY_P_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            ready_q      <= ready_d;
`ifdef DATA_MEMORY_P_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    // Array write port, shared by the clear sequencer and normal writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

`ifdef DATA_MEMORY_P_PARITY_EN
    // Parity array follows the data array write for write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_mem[mem_idx] <= mem_wpar;
        end
    end
`endif

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign ready      = ready_q;
`ifdef DATA_MEMORY_P_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_p.sv
module tb_data_memory_p;

    logic        clk;
    logic        rst_n;
    logic [3:0]  address;
    logic [15:0] write_data;
    logic [1:0]  byte_en;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] read_data;
    logic        read_valid;
    logic        ready;
    logic        par_err;

    typedef struct {
        logic [15:0] data;
        logic        perr;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    data_memory_p #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .write_data   (write_data),
        .byte_en      (byte_en),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .ready        (ready),
        .par_err      (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Monitor: every read_valid strobe must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && read_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_read_valid: got data=%h par_err=%b, none expected", read_data, par_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (read_data !== e.data || par_err !== e.perr) begin
                    fails++;
                    $display("FAIL read_resp: got data=%h par_err=%b, expected data=%h par_err=%b",
                             read_data, par_err, e.data, e.perr);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // One request cycle; entered and left at posedge+1.
    task automatic op(input bit we, input bit re, input logic [3:0] a, input logic [15:0] wd,
                      input logic [1:0] be, input logic [15:0] exp_d, input bit exp_p);
        write_enable = we;
        read_enable  = re;
        address      = a;
        write_data   = wd;
        byte_en      = be;
        if (re) exp_q.push_back('{exp_d, exp_p});
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        byte_en      = 2'b00;
    endtask

    task automatic wait_clear(input string nm);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            check(nm, {31'd0, ready}, {31'd0, (k == 16)});
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b1;
        address      = 4'd5;
        write_data   = 16'h0000;
        byte_en      = 2'b00;
        write_enable = 1'b0;
        read_enable  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",      {31'd0, ready},      32'd0);
        check("rst_read_valid", {31'd0, read_valid}, 32'd0);
        check("rst_read_data",  {16'd0, read_data},  32'd0);
        check("rst_par_err",    {31'd0, par_err},    32'd0);

        // Clear with read_enable held: no strobes, ready after exactly 16 edges.
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("clear_ready");
        op(0, 1, 4'd5, 16'h0000, 2'b00, 16'h0000, 0);

        // Basic write/read, byte enables, write-first, top address.
        op(1, 0, 4'd0,  16'hA5A5, 2'b11, 16'h0000, 0);
        op(0, 1, 4'd0,  16'h0000, 2'b00, 16'hA5A5, 0);
        op(1, 0, 4'd5,  16'h1234, 2'b11, 16'h0000, 0);
        op(0, 1, 4'd5,  16'h0000, 2'b00, 16'h1234, 0);
        op(1, 0, 4'd3,  16'hA5A5, 2'b11, 16'h0000, 0);
        op(1, 0, 4'd3,  16'h1234, 2'b01, 16'h0000, 0);
        op(0, 1, 4'd3,  16'h0000, 2'b00, 16'hA534, 0);
        op(1, 0, 4'd3,  16'hFFFF, 2'b00, 16'h0000, 0);
        op(0, 1, 4'd3,  16'h0000, 2'b00, 16'hA534, 0);
        op(1, 1, 4'd7,  16'hBEEF, 2'b10, 16'hBE00, 0);
        op(0, 1, 4'd7,  16'h0000, 2'b00, 16'hBE00, 0);
        op(1, 0, 4'd15, 16'hCAFE, 2'b11, 16'h0000, 0);
        op(0, 1, 4'd15, 16'h0000, 2'b00, 16'hCAFE, 0);

        // Back-to-back reads, then an idle cycle holds data and drops valid.
        op(0, 1, 4'd0, 16'h0000, 2'b00, 16'hA5A5, 0);
        op(0, 1, 4'd5, 16'h0000, 2'b00, 16'h1234, 0);
        op(0, 1, 4'd3, 16'h0000, 2'b00, 16'hA534, 0);
        op(0, 0, 4'd0, 16'h0000, 2'b00, 16'h0000, 0);
        check("idle_valid_low", {31'd0, read_valid}, 32'd0);
        check("idle_data_hold", {16'd0, read_data},  32'h0000A534);

        // Reset with a read in flight: the strobe is discarded.
        address     = 4'd0;
        read_enable = 1'b1;
        @(posedge clk);
        #1;
        read_enable = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("inflight_valid", {31'd0, read_valid}, 32'd0);
        check("inflight_ready", {31'd0, ready},      32'd0);
        check("inflight_data",  {16'd0, read_data},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again at clear cycle 8; the clear restarts from word 0.
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midclear_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("reclear_ready");
        for (int a = 0; a < 16; a++) begin
            op(0, 1, 4'(a), 16'h0000, 2'b00, 16'h0000, 0);
        end

`ifdef DATA_MEMORY_P_PARITY_EN
        op(1, 0, 4'd2, 16'h00FF, 2'b11, 16'h0000, 0);
        dut.par_mem[2][0] = ~dut.par_mem[2][0];
        op(0, 1, 4'd2, 16'h0000, 2'b00, 16'h00FF, 1);
        op(0, 1, 4'd1, 16'h0000, 2'b00, 16'h0000, 0);
`endif

        repeat (3) op(0, 0, 4'd0, 16'h0000, 2'b00, 16'h0000, 0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
